fir_mac_filter: RTL and testbench

//   Parametrised FIR filter with a time-multiplexed single multiply-accumulate unit (one tap per clock).

---
 rtl/fir_mac_filter.sv | 242 ++++++++++++++++++++++++
 tb/tb_fir_mac_filter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// fir_mac_filter
//   FIR filter built around one multiply-accumulate unit that handles one tap
//   per clock. Coefficients are written at run time through the coeff_* port.
//   The full-precision accumulator is rounded (half toward +inf), arithmetically
//   shifted right by OUT_SHIFT, and saturated to DATA_W bits.
//   Sequence: IDLE (accept a sample) -> MAC (N cycles) -> OUT (hold the result
//   until downstream takes it) -> IDLE.
//
// Ports
//   clk, reset_n            clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready       sample handshake; in_ready is high only in IDLE
//   in_data   [DATA_W]      signed input sample
//   out_valid/out_ready     result handshake
//   out_data  [DATA_W]      signed filtered sample
//   out_ovf                 out_data was saturated; qualified by out_valid
//   coeff_we/addr/data      coefficient write; ignored while busy or addr>=N
//   busy                    high while the MAC is running

module fir_mac_filter #(
    parameter int N         = 32,
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_ovf,
    input  logic                     coeff_we,
    input  logic [$clog2(N)-1:0]     coeff_addr,
    input  logic [COEFF_W-1:0]       coeff_data,
    output logic                     busy
);

    localparam int AW     = $clog2(N);
    localparam int ACC_W  = DATA_W + COEFF_W + AW;
    localparam int PROD_W = DATA_W + COEFF_W;

    localparam logic [AW:0]   N_LIM    = (AW+1)'(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    // Saturation limits expressed at the widened (ACC_W+1) precision.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      out_ovf_q, out_ovf_d;
    logic                      out_valid_q, out_valid_d;

    // Per-tap storage, gathered into arrays for the MAC read mux.
    logic signed [DATA_W-1:0]  dline_taps [N];
    logic signed [COEFF_W-1:0] coeff_taps [N];

    logic accept;
    logic coeff_addr_ok;
    logic coeff_wr;

    assign accept        = (state_q == ST_IDLE) && in_valid;
    assign coeff_addr_ok = ({1'b0, coeff_addr} < N_LIM);
    assign coeff_wr      = coeff_we && (state_q != ST_MAC) && coeff_addr_ok;

    // ------------------------------------------------------------------
    // Delay line and coefficient registers, one generate slice per tap
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_tap
            logic signed [DATA_W-1:0]  dline_q, dline_d;
            logic signed [COEFF_W-1:0] coeff_q, coeff_d;
            logic signed [DATA_W-1:0]  shift_in;

            if (gi == 0) begin : g_head
                assign shift_in = in_data;
            end else begin : g_body
                assign shift_in = dline_taps[gi-1];
            end

            always_comb begin
                dline_d = dline_q;
                coeff_d = coeff_q;
                if (accept) begin
                    dline_d = shift_in;
                end
                // A write landing on the accept edge is already in place
                // when the MAC reads this tap on a later edge.
                if (coeff_wr && (coeff_addr == AW'(gi))) begin
                    coeff_d = coeff_data;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dline_q <= '0;
                    coeff_q <= '0;
                end else begin
                    dline_q <= dline_d;
                    coeff_q <= coeff_d;
                end
            end

            assign dline_taps[gi] = dline_q;
            assign coeff_taps[gi] = coeff_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multiply-accumulate datapath
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0]  tap_sample;
    logic signed [COEFF_W-1:0] tap_coeff;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;

    assign tap_sample = dline_taps[idx_q];
    assign tap_coeff  = coeff_taps[idx_q];
    assign prod       = tap_sample * tap_coeff;
    assign acc_sum    = acc_q + {{AW{prod[PROD_W-1]}}, prod};

    // ------------------------------------------------------------------
    // Round and saturate. One extra bit of headroom keeps the rounding
    // bias from wrapping a near-full-scale accumulator.
    // ------------------------------------------------------------------
    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] rounded;

    assign acc_ext = {acc_sum[ACC_W-1], acc_sum};

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF =
                {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
            logic signed [ACC_W:0] biased;
            assign biased  = acc_ext + HALF;
            assign rounded = biased >>> OUT_SHIFT;
        end else begin : g_no_round
            assign rounded = acc_ext;
        end
    endgenerate

    logic [DATA_W-1:0] sat_data;
    logic              sat_ovf;

    always_comb begin
        sat_data = rounded[DATA_W-1:0];
        sat_ovf  = 1'b0;
        if (rounded > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_W-1:0];
            sat_ovf  = 1'b1;
        end else if (rounded < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_W-1:0];
            sat_ovf  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and datapath register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end

            ST_MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + AW'(1);
                // The last tap's product is folded in combinationally so the
                // result registers on the same edge as the final accumulate.
                if (idx_q == LAST_IDX) begin
                    out_data_d  = sat_data;
                    out_ovf_d   = sat_ovf;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_MAC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter
//   Three filter instances share one clock and reset:
//     dut_a  N=4,  OUT_SHIFT=0   } driven from the same input signals, so each
//     dut_b  N=4,  OUT_SHIFT=15  } vector carries expected results for both
//     dut_c  N=32, OUT_SHIFT=0     throughput and latency
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_fir_mac_filter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for dut_a / dut_b
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               out_ready = 1'b0;
    logic               coeff_we = 1'b0;
    logic [1:0]         coeff_addr = '0;
    logic signed [15:0] coeff_data = '0;

    logic               in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic signed [15:0] out_data_a;
    logic               in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic signed [15:0] out_data_b;

    // dut_c stimulus
    logic               in_valid_c = 1'b0;
    logic signed [15:0] in_data_c = '0;
    logic               out_ready_c = 1'b1;
    logic               coeff_we_c = 1'b0;
    logic [4:0]         coeff_addr_c = '0;
    logic signed [15:0] coeff_data_c = '0;
    logic               in_ready_c, out_valid_c, out_ovf_c, busy_c;
    logic signed [15:0] out_data_c;

    fir_mac_filter #(.N(4), .DATA_W(16), .COEFF_W(16), .OUT_SHIFT(0)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ovf(out_ovf_a),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .busy(busy_a)
    );

    fir_mac_filter #(.N(4), .DATA_W(16), .COEFF_W(16), .OUT_SHIFT(15)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ovf(out_ovf_b),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .busy(busy_b)
    );

    fir_mac_filter #(.N(32), .DATA_W(16), .COEFF_W(16), .OUT_SHIFT(0)) dut_c (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .out_ovf(out_ovf_c),
        .coeff_we(coeff_we_c), .coeff_addr(coeff_addr_c), .coeff_data(coeff_data_c),
        .busy(busy_c)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Vector: optional coefficient load, one sample, expected outputs of both DUTs
    typedef struct {
        string name;
        bit    load;
        int    c0, c1, c2, c3;
        int    x;
        int    y0;
        bit    o0;
        int    y15;
        bit    o15;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input bit load,
                           input int c0, input int c1, input int c2, input int c3,
                           input int x, input int y0, input bit o0,
                           input int y15, input bit o15);
        vec_t v;
        v.name = name; v.load = load;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
        v.x = x; v.y0 = y0; v.o0 = o0; v.y15 = y15; v.o15 = o15;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            coeff_we   = 1'b1;
            coeff_addr = 2'(i);
            coeff_data = 16'(c[i]);
            tick();
        end
        coeff_we = 1'b0;
    endtask

    // Waits (bounded) for out_valid_a; lat counts edges from the call.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid_a && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".valid_drop"}, out_valid_a, 0);
    endtask

    // Accepts one sample (any coefficient write already set up rides the
    // same edge), waits for the result, checks both DUTs, then drains it.
    task automatic run_vec(input string name, input int x,
                           input int y0, input bit o0, input int y15, input bit o15);
        int lat;
        check({name, ".in_ready"}, in_ready_a, 1);
        in_valid = 1'b1;
        in_data  = 16'(x);
        tick();
        in_valid = 1'b0;
        coeff_we = 1'b0;
        wait_out(lat);
        check({name, ".latency"}, lat, 4);
        check({name, ".y_a"}, out_data_a, y0);
        check({name, ".ovf_a"}, out_ovf_a, o0);
        check({name, ".valid_b"}, out_valid_b, 1);
        check({name, ".y_b"}, out_data_b, y15);
        check({name, ".ovf_b"}, out_ovf_b, o15);
        $display("vec %s: x=%0d y_a=%0d ovf_a=%0d y_b=%0d ovf_b=%0d lat=%0d",
                 name, x, out_data_a, out_ovf_a, out_data_b, out_ovf_b, lat);
        handshake(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        int acc_edge[8];
        int acc_val[8];
        int out_edge[8];
        int out_val[8];
        int na;
        int no;

        // ---------------- stimulus table ----------------
        // impulse, OUT_SHIFT=0 gives the coefficients back
        add_vec("imp0", 1, 1, 2, 3, 4,      1,      1, 0,      0, 0);
        add_vec("imp1", 0, 0, 0, 0, 0,      0,      2, 0,      0, 0);
        add_vec("imp2", 0, 0, 0, 0, 0,      0,      3, 0,      0, 0);
        add_vec("imp3", 0, 0, 0, 0, 0,      0,      4, 0,      0, 0);
        add_vec("imp4", 0, 0, 0, 0, 0,      0,      0, 0,      0, 0);
        // rounding, coeff0=0.5 in Q15
        add_vec("rnd+3", 1, 16384, 0, 0, 0, 3,  32767, 1,      2, 0);
        add_vec("rnd-3", 0, 0, 0, 0, 0,    -3, -32768, 1,     -1, 0);
        add_vec("rnd+1", 0, 0, 0, 0, 0,     1,  16384, 0,      1, 0);
        // full-scale coefficients; history 1,-3,3 still in the delay line
        add_vec("sat0", 1, 32767, 32767, 32767, 32767, 32767, 32767, 1, 32767, 0);
        add_vec("sat1", 0, 0, 0, 0, 0,  32767,  32767, 1,  32767, 1);
        add_vec("sat2", 0, 0, 0, 0, 0,  32767,  32767, 1,  32767, 1);
        add_vec("sat3", 0, 0, 0, 0, 0,  32767,  32767, 1,  32767, 1);
        add_vec("sat4", 0, 0, 0, 0, 0, -32768,  32767, 1,  32767, 1);
        add_vec("sat5", 0, 0, 0, 0, 0, -32768, -32768, 1,     -2, 0);
        add_vec("sat6", 0, 0, 0, 0, 0, -32768, -32768, 1, -32768, 1);
        add_vec("sat7", 0, 0, 0, 0, 0, -32768, -32768, 1, -32768, 1);
        // extremes passing through unity gain without overflow
        add_vec("edge+", 1, 1, 0, 0, 0,  32767,  32767, 0,      1, 0);
        add_vec("edge-", 0, 0, 0, 0, 0, -32768, -32768, 0,     -1, 0);

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("reset.in_ready",  in_ready_a, 1);
        check("reset.out_valid", out_valid_a, 0);
        check("reset.busy",      busy_a, 0);
        check("reset.out_data",  out_data_a, 0);
        check("reset.out_ovf",   out_ovf_a, 0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            if (vecs[i].load) load4(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
            run_vec(vecs[i].name, vecs[i].x, vecs[i].y0, vecs[i].o0,
                    vecs[i].y15, vecs[i].o15);
        end

        // ---------------- backpressure ----------------
        in_valid = 1'b1;
        in_data  = 16'sd7;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("bp.latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'sd999;
            tick();
            check("bp.valid_hold", out_valid_a, 1);
            check("bp.data_hold",  out_data_a, 7);
            check("bp.ovf_hold",   out_ovf_a, 0);
            check("bp.in_ready",   in_ready_a, 0);
        end
        in_valid = 1'b0;
        $display("seq backpressure: held y_a=%0d for 10 cycles", out_data_a);
        handshake("bp");
        check("bp.idle", in_ready_a, 1);
        // the 999 pulses must not have entered the delay line
        load4(0, 1, 0, 0);
        run_vec("bp.history", 0, 7, 0, 0, 0);

        // ---------------- coefficient write while busy ----------------
        load4(1, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'sd3;
        tick();
        in_valid   = 1'b0;
        coeff_we   = 1'b1;
        coeff_addr = 2'd0;
        coeff_data = 16'sd100;
        check("macwr.busy", busy_a, 1);
        tick();
        coeff_we = 1'b0;
        wait_out(lat);
        check("macwr.latency", lat + 1, 4);
        check("macwr.y_a", out_data_a, 3);
        $display("seq macwr: y_a=%0d", out_data_a);
        handshake("macwr");
        run_vec("macwr.after", 2, 2, 0, 0, 0);

        // ---------------- reset in the middle of MAC ----------------
        load4(1, 1, 1, 1);
        in_valid = 1'b1;
        in_data  = 16'sd9;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst.out_valid", out_valid_a, 0);
        check("midrst.busy", busy_a, 0);
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid_a) seen++;
        end
        check("midrst.no_output", seen, 0);
        check("midrst.in_ready", in_ready_a, 1);
        $display("seq midrst: spurious outputs=%0d", seen);
        load4(1, 2, 3, 4);
        run_vec("restart0", 1, 1, 0, 0, 0);
        run_vec("restart1", 0, 2, 0, 0, 0);
        run_vec("restart2", 0, 3, 0, 0, 0);
        run_vec("restart3", 0, 4, 0, 0, 0);

        // ---------------- coefficient write on the accept edge ----------------
        coeff_we   = 1'b1;
        coeff_addr = 2'd0;
        coeff_data = 16'sd5;
        run_vec("coinc", 2, 10, 0, 0, 0);

        // ---------------- throughput, N=32 ----------------
        coeff_we_c   = 1'b1;
        coeff_addr_c = 5'd0;
        coeff_data_c = 16'sd1;
        tick();
        coeff_we_c = 1'b0;
        in_valid_c = 1'b1;
        na = 0;
        no = 0;
        for (int c = 0; c < 150; c++) begin
            in_data_c = 16'(100 + c);
            if (in_ready_c && na < 8) begin
                acc_edge[na] = c + 1;
                acc_val[na]  = 100 + c;
                na++;
            end
            tick();
            if (out_valid_c && no < 8) begin
                out_edge[no] = c + 1;
                out_val[no]  = out_data_c;
                no++;
            end
        end
        in_valid_c = 1'b0;
        check("thr.accepts", na, 5);
        check("thr.outputs", no, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < na && k < no) begin
                if (k > 0) check("thr.spacing", acc_edge[k] - acc_edge[k-1], 34);
                check("thr.latency", out_edge[k] - acc_edge[k], 32);
                check("thr.data", out_val[k], acc_val[k]);
                $display("thr %0d: accept@%0d x=%0d output@%0d y=%0d",
                         k, acc_edge[k], acc_val[k], out_edge[k], out_val[k]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
